csa_resolver: RTL

- Carry-propagate stage that takes the redundant sum/carry vectors from the carry-save array and resolves them into one binary result.
- Computes result = sum + (carry << 1) using a CHUNK-bit ripple slice over several cycles, with a carry register between chunks, so area stays small.
- Sits after the last CSA row of the Booth multiplier datapath.
- Uses valid/ready handshakes on both sides.

---
 rtl/csa_resolver.sv | 116 +++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate resolver: result = sum + (carry << 1), resolved CHUNK bits per cycle
// with a carry register between slices. Valid/ready handshakes on both sides.
module csa_resolver #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH+2:0]   sum_in,
    input  logic [WIDTH+2:0]   carry_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [WIDTH+4:0]   result_out,
    output logic               valid_out,
    input  logic               ready_in
);

    localparam int RW     = WIDTH + 5;
    localparam int NCHUNK = (RW + CHUNK - 1) / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [RW-1:0] SLICE_MASK = RW'({CHUNK{1'b1}});

    generate
        if (CHUNK < 1 || CHUNK > RW) begin : g_bad_chunk
            $error("csa_resolver: CHUNK must be in 1..RW");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   a_q, a_d;
    logic [RW-1:0]   b_q, b_d;
    logic [RW-1:0]   res_q, res_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;

    int              shamt;
    logic [RW-1:0]   a_sh, b_sh, slice_val;
    logic [CHUNK:0]  slice_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Current slice: shifting the operands down keeps every select at a constant index,
    // and bits shifted in from above RW are zero, so a narrow last slice needs no special case.
    always_comb begin
        shamt     = int'(idx_q) * CHUNK;
        a_sh      = a_q >> shamt;
        b_sh      = b_q >> shamt;
        slice_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        slice_val = RW'(slice_sum[CHUNK-1:0]);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        ready_out = 1'b0;
        valid_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    a_d     = {2'b00, sum_in};
                    b_d     = {1'b0, carry_in, 1'b0};
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                res_d   = (res_q & ~(SLICE_MASK << shamt)) | (slice_val << shamt);
                carry_d = slice_sum[CHUNK];
                if (idx_q == IW'(NCHUNK - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                valid_out = 1'b1;
                if (ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign result_out = res_q;

endmodule
